// File: rtl/tb_mem_rsp.sv
// Memory-side responder: accepts line requests into an in-order queue backed by a
// line store and returns each response once its minimum latency has elapsed.
module tb_mem_rsp #(
    parameter int IDX_W  = 4,
    parameter int MCN_W  = 36,
    parameter int PCN_W  = 28,
    parameter int DATA_W = 512,
    parameter int DEPTH  = 8,
    parameter int LAT    = 4,
    parameter int WORDS  = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     mem_req_o_ready,
    input  logic                     mem_req_o_valid,
    input  logic [IDX_W-1:0]         mem_req_o_bits_idx,
    input  logic                     mem_req_o_bits_rnw,
    input  logic [MCN_W-1:0]         mem_req_o_bits_mcn,
    input  logic [PCN_W-1:0]         mem_req_o_bits_pcn,
    input  logic [DATA_W-1:0]        mem_req_o_bits_data,
    input  logic                     mem_resp_i_ready,
    output logic                     mem_resp_i_valid,
    output logic [IDX_W-1:0]         mem_resp_i_bits_idx,
    output logic                     mem_resp_i_bits_err,
    output logic                     mem_resp_i_bits_rnw,
    output logic [DATA_W-1:0]        mem_resp_i_bits_data,
    input  logic                     stall_i,
    output logic [$clog2(DEPTH):0]   occ_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(WORDS);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    // Handshake: a transfer happens on a rising clock edge where valid && ready;
    // a producer holding valid keeps its bits stable until that edge.

    logic [AW:0]              wr_ptr, rd_ptr, occ;
    logic                     full, push, pop, load, head_live, next_ok, req_err;
    logic [AW-1:0]            head;
    logic [DEPTH-1:0][CW-1:0] cnt_q;

    logic [IDX_W-1:0]  idx_m  [DEPTH];
    logic              rnw_m  [DEPTH];
    logic              err_m  [DEPTH];
    logic [DATA_W-1:0] data_m [DEPTH];
    logic [DATA_W-1:0] store  [WORDS];

    assign occ             = wr_ptr - rd_ptr;
    assign occ_o           = occ;
    assign full            = (occ == (AW+1)'(DEPTH));
    assign mem_req_o_ready = !reset && !full && !stall_i;
    assign push            = mem_req_o_valid && mem_req_o_ready;
    assign pop             = mem_resp_i_valid && mem_resp_i_ready;
    assign req_err         = (mem_req_o_bits_pcn >= PCN_W'(WORDS));

    // On a pop the candidate is the entry behind the head, so a ready successor
    // is presented on the very next cycle without a bubble.
    always_comb begin
        head      = rd_ptr[AW-1:0];
        head_live = (occ != '0);
        if (pop) begin
            head      = rd_ptr[AW-1:0] + AW'(1);
            head_live = (occ > (AW+1)'(1));
        end
        load    = !mem_resp_i_valid || pop;
        next_ok = head_live && (cnt_q[head] == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            cnt_q                <= '0;
            mem_resp_i_valid     <= 1'b0;
            mem_resp_i_bits_idx  <= '0;
            mem_resp_i_bits_err  <= 1'b0;
            mem_resp_i_bits_rnw  <= 1'b0;
            mem_resp_i_bits_data <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CW'(1);
            end
            if (push) begin
                cnt_q[wr_ptr[AW-1:0]] <= CW'(LAT - 1);
                wr_ptr                <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (load) begin
                mem_resp_i_valid <= next_ok;
                if (next_ok) begin
                    mem_resp_i_bits_idx  <= idx_m[head];
                    mem_resp_i_bits_err  <= err_m[head];
                    mem_resp_i_bits_rnw  <= rnw_m[head];
                    mem_resp_i_bits_data <= data_m[head];
                end
            end
        end
    end

    // Payload storage carries no reset; only pointer-qualified entries are ever read.
    always_ff @(posedge clock) begin
        if (push) begin
            idx_m[wr_ptr[AW-1:0]]  <= mem_req_o_bits_idx;
            rnw_m[wr_ptr[AW-1:0]]  <= mem_req_o_bits_rnw;
            err_m[wr_ptr[AW-1:0]]  <= req_err;
            data_m[wr_ptr[AW-1:0]] <= (mem_req_o_bits_rnw && !req_err)
                                      ? store[mem_req_o_bits_pcn[SW-1:0]] : '0;
            if (!mem_req_o_bits_rnw && !req_err)
                store[mem_req_o_bits_pcn[SW-1:0]] <= mem_req_o_bits_data;
        end
    end

    a_no_push_full: assert property (@(posedge clock) disable iff (reset) !(push && full));
    a_no_pop_empty: assert property (@(posedge clock) disable iff (reset) !(pop && occ == '0));
    a_resp_stable: assert property (@(posedge clock) disable iff (reset)
        (mem_resp_i_valid && !mem_resp_i_ready) |=>
        (mem_resp_i_valid && $stable(mem_resp_i_bits_idx) && $stable(mem_resp_i_bits_err)
         && $stable(mem_resp_i_bits_rnw) && $stable(mem_resp_i_bits_data)));
    a_resp_tag: assert property (@(posedge clock) disable iff (reset)
        mem_resp_i_valid |-> (mem_resp_i_bits_idx == idx_m[rd_ptr[AW-1:0]]));
    a_mcn_known: assert property (@(posedge clock) disable iff (reset)
        mem_req_o_valid |-> !$isunknown(mem_req_o_bits_mcn));

endmodule

// File: doc/tb_mem_rsp.md
Name: tb_mem_rsp

Overview:
- Parametrised memory-side responder for the MMU bench. Replaces ad-hoc interface-driven memory stubs.
- Accepts MMU memory requests on the mem_req_o channel and keeps a backing store.
- Returns in-order responses on the mem_resp_i channel after a programmable minimum latency.
- Supports up to DEPTH outstanding requests, back-pressure injection and out-of-range error responses.

Parameters:
- IDX_W, 4: request/response tag width
- MCN_W, 36: mcn field width (carried, not interpreted)
- PCN_W, 28: pcn field width
- DATA_W, 512: line data width
- DEPTH, 8: max outstanding requests (power of 2, >=2)
- LAT, 4: minimum accept-to-response-valid cycles (>=1)
- WORDS, 1024: backing-store lines; pcn >= WORDS is out of range

Ports:
- clock  in  1  block clock
- reset  in  1  asynchronous, active-high reset
- mem_req_o_ready  out  1  request accept
- mem_req_o_valid  in  1  request valid
- mem_req_o_bits_idx  in  IDX_W  request tag
- mem_req_o_bits_rnw  in  1  1=read, 0=write
- mem_req_o_bits_mcn  in  MCN_W  ignored except for tracing
- mem_req_o_bits_pcn  in  PCN_W  line address
- mem_req_o_bits_data  in  DATA_W  write data
- mem_resp_i_ready  in  1  response accept
- mem_resp_i_valid  out  1  response valid
- mem_resp_i_bits_idx  out  IDX_W  echoed tag
- mem_resp_i_bits_err  out  1  out-of-range access
- mem_resp_i_bits_rnw  out  1  echoed rnw
- mem_resp_i_bits_data  out  DATA_W  read data; 0 for writes and errors
- stall_i  in  1  forces mem_req_o_ready low this cycle
- occ_o  out  $clog2(DEPTH)+1  outstanding entry count

Behaviour:
- Reset (async assert, sync-to-clock release):
  - mem_req_o_ready=0, mem_resp_i_valid=0, all resp bits 0, occ_o=0, queue empty.
  - Backing store is not reset.
  - Reset mid-operation discards every queued entry; no response is issued after release.
- mem_req_o_ready = !reset && !full && !stall_i.
  - full is a registered state (occ==DEPTH). There is no same-cycle pop-bypass: when full, a pop makes space from the next cycle only.
- Accept happens on valid && ready at a posedge. The accepted entry is pushed at the FIFO tail with {idx, rnw, err, data, cnt=LAT-1}.
  - err = (pcn >= WORDS).
  - Write, no err: store[pcn] <= data at the accept edge; entry data = 0.
  - Read, no err: entry data = store[pcn] sampled at the accept edge, so it reflects every previously accepted write.
  - err: store untouched; entry data = 0.
- Each entry's cnt decrements every cycle, saturating at 0, independent of position.
- Head becomes eligible when cnt==0. mem_resp_i_valid is registered from head eligibility.
  - A request accepted at edge N yields mem_resp_i_valid=1 no earlier than edge N+LAT when all prior responses have drained.
- Response bits are driven from the head entry and stay stable while valid && !ready. Valid never drops without a handshake.
- Pop happens on valid && ready. The next head may assert valid in the following cycle only (max one response per 2 cycles is NOT allowed). Back-to-back responses are required when successive heads are already eligible: valid stays high and bits update on the pop edge.
- Simultaneous push and pop: occ_o unchanged, both take effect.
- Pointers wrap modulo DEPTH. occ_o is the pointer difference plus the wrap bit.
- Ordering: responses leave strictly in acceptance order, regardless of rnw or err.
- Assertions:
  - No push when full.
  - No pop when empty.
  - Resp bits stable under stall.
  - Tag of every response equals the tag of the oldest outstanding request.

Test Plan:
- Single write then read: write pcn=5 data=0xA5..A5 idx=1, read pcn=5 idx=2 with ready held 1 -> responses idx=1 (rnw=0, data=0, err=0) at accept+4, then idx=2 (rnw=1, data=0xA5..A5).
- Fill: 8 reads with stall_i=0 and mem_resp_i_ready=0 -> occ_o reaches 8, ready drops. Release ready for one pop -> ready rises the next cycle, occ_o=7.
- Back-pressure: hold mem_resp_i_ready=0 for 20 cycles with valid=1 -> idx/data/err unchanged all 20 cycles. Then 8 back-to-back pops, one per cycle.
- Out-of-range: write pcn=1024 data=0xFF.., then read pcn=1024 -> both err=1, data=0. A prior read of pcn=0 returns unchanged contents.
- Stall injection: stall_i toggling every cycle under 16 requests with random rnw -> ready=0 exactly on stall cycles. All 16 responses are in order with correct tags.
- Async reset with 5 outstanding: assert reset mid-cycle -> valid and ready fall immediately, occ_o=0. After release, no stale response appears within 2*LAT cycles.
